// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit layout and the serialiser state encoding.
package mmio_uart_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int BUSY    = 0;
  localparam int FULL    = 1;
  localparam int EMPTY   = 2;
  localparam int OVF     = 3;
  localparam int CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [3:0] cnt);
    logic [31:0] s;
    s              = '0;
    s[BUSY]        = busy;
    s[FULL]        = full;
    s[EMPTY]       = empty;
    s[OVF]         = ovf;
    s[CNT_LSB +: 4] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the bus and the serialiser. Push when full and pop when
// empty are ignored; both are judged on the count held before the edge.
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; an entry is only ever read after a
  // push has written it, so clearing it would cost logic and buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is exactly what lets a push and a pop in one cycle both see the old count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a FIFO,
// STATUS reports busy/full/empty/overflow/count, a baud FSM drives tx.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0020,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_e      state;
  logic [BW-1:0]  baud;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           overflow;

  logic           sel_data;
  logic           sel_status;
  logic           push;
  logic           pop;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           bit_end;
  logic           unused_bits;

  assign sel_data   = (Address == BASE_ADDR + TXDATA_OFS) && (Address[1:0] == 2'b00);
  assign sel_status = (Address == BASE_ADDR + STATUS_OFS) && (Address[1:0] == 2'b00);
  assign hit        = sel_data || sel_status;
  assign unused_bits = ^Write_data[31:8];

  assign push    = MemWrite && sel_data;
  assign pop     = (state == IDLE) && !empty;
  assign bit_end = (baud == BW'(CLKS_PER_BIT - 1));

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (Write_data[7:0]),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every path assigns a default first, so no latch is inferred.
  always_comb begin
    Read_data = '0;
    if (MemRead && sel_status)
      Read_data = pack_status(state != IDLE, full, empty, overflow, 4'(count));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && full)
        overflow <= 1'b1;
      else if (MemWrite && sel_status && Write_data[OVF])
        overflow <= 1'b0;

      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= fifo_dout;
            baud  <= '0;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud    <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            // tx already shows the next bit at the boundary, so use shift[1]
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud  <= '0;
            state <= IDLE;
            tx    <= 1'b1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a decode table, hand-written frame
// sequences and random bus traffic, all compared against a queue-based model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h4000_0020;
  localparam int          CPB  = 4;
  localparam int          DEP  = 8;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        hit;
  logic        tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .hit        (hit),
    .tx         (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: queued bytes, current byte and position inside its frame
  // (-1 when the line is idle). A frame is 10 bit periods: start, 8 data, stop.
  logic [7:0] q [$];
  logic [7:0] cur;
  int         frame_pos = -1;
  logic       m_ovf     = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int          cnt;
    cnt    = q.size();
    s      = 32'd0;
    s[0]   = (frame_pos >= 0);
    s[1]   = (cnt == DEP);
    s[2]   = (cnt == 0);
    s[3]   = m_ovf;
    s[7:4] = 4'(cnt);
    return s;
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    return (a == BASE) || (a == BASE + 32'd4);
  endfunction

  function automatic logic [31:0] m_rdata(input logic rd, input logic [31:0] a);
    return (rd && a == BASE + 32'd4) ? m_status() : 32'd0;
  endfunction

  function automatic logic m_tx();
    int k;
    if (frame_pos < 0) return 1'b1;
    k = frame_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return cur[k-1];
  endfunction

  task automatic m_reset();
    q.delete();
    frame_pos = -1;
    m_ovf     = 1'b0;
  endtask

  task automatic m_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int  pre;
    logic idle;
    if (reset) begin
      m_reset();
      return;
    end
    pre  = q.size();
    idle = (frame_pos < 0);
    if (frame_pos >= 0) begin
      frame_pos++;
      if (frame_pos == 10 * CPB) frame_pos = -1;
    end
    if (idle && pre > 0) begin
      cur       = q.pop_front();
      frame_pos = 0;
    end
    if (wr && a == BASE) begin
      if (pre < DEP) q.push_back(d[7:0]);
      else           m_ovf = 1'b1;
    end
    if (wr && a == BASE + 32'd4 && d[3]) m_ovf = 1'b0;
  endtask

  // One clock: drive at the falling edge, check combinational outputs, take the
  // rising edge, advance the model, check tx, return at the next falling edge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead    = rd;
    MemWrite   = wr;
    Address    = a;
    Write_data = d;
    #1;
    check("hit", {31'd0, hit}, {31'd0, m_hit(a)});
    check("read_data", Read_data, m_rdata(rd, a));
    @(posedge clk);
    m_edge(wr, a, d);
    cyc++;
    #1;
    check("tx", {31'd0, tx}, {31'd0, m_tx()});
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int         f0;
    int         f1;
    logic       prev;
    logic       exp_bit;
    logic [7:0] b55;
    int         k;
    int         r;
    logic [31:0] a;

    reset      = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = 32'd0;
    Write_data = 32'd0;

    // Reset state
    idle_n(3);
    check("reset_tx", {31'd0, tx}, 32'd1);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("reset_status", Read_data, 32'h0000_0004);
    reset = 1'b0;
    idle_n(2);

    // Address decode table, applied while idle and empty
    vecs.push_back('{"rd_status",    1'b1, 1'b0, BASE + 32'd4, 32'd0,  1'b1, 32'h4});
    vecs.push_back('{"rd_txdata",    1'b1, 1'b0, BASE,         32'd0,  1'b1, 32'h0});
    vecs.push_back('{"rd_base8",     1'b1, 1'b0, BASE + 32'd8, 32'd0,  1'b0, 32'h0});
    vecs.push_back('{"rd_base1",     1'b1, 1'b0, BASE + 32'd1, 32'd0,  1'b0, 32'h0});
    vecs.push_back('{"rd_base5",     1'b1, 1'b0, BASE + 32'd5, 32'd0,  1'b0, 32'h0});
    vecs.push_back('{"status_nord",  1'b0, 1'b0, BASE + 32'd4, 32'd0,  1'b1, 32'h0});
    vecs.push_back('{"wr_base8",     1'b0, 1'b1, BASE + 32'd8, 32'h77, 1'b0, 32'h0});
    vecs.push_back('{"wr_base1",     1'b0, 1'b1, BASE + 32'd1, 32'h77, 1'b0, 32'h0});
    vecs.push_back('{"wr_status",    1'b0, 1'b1, BASE + 32'd4, 32'hFF, 1'b1, 32'h0});
    vecs.push_back('{"rd_after_miss",1'b1, 1'b0, BASE + 32'd4, 32'd0,  1'b1, 32'h4});
    vecs.push_back('{"rd_zero",      1'b1, 1'b0, 32'd0,        32'd0,  1'b0, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      MemRead    = vecs[i].rd;
      MemWrite   = vecs[i].wr;
      Address    = vecs[i].addr;
      Write_data = vecs[i].data;
      #1;
      check({vecs[i].name, "_hit"}, {31'd0, hit}, {31'd0, vecs[i].exp_hit});
      check({vecs[i].name, "_rdata"}, Read_data, vecs[i].exp_rdata);
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      check("miss_line_idle", {31'd0, tx}, 32'd1);
    end

    // Single frame of 0x55
    b55 = 8'h55;
    step(1'b0, 1'b1, BASE, 32'h55);
    check("tx_before_pop", {31'd0, tx}, 32'd1);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0);
      k = (i - 1) / CPB;
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = b55[k-1];
      check("frame55", {31'd0, tx}, {31'd0, exp_bit});
    end
    step(1'b0, 1'b0, 32'd0, 32'd0);
    check("after_frame_tx", {31'd0, tx}, 32'd1);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("after_frame_status", Read_data, 32'h0000_0004);

    // Back-to-back frames: start bits 41 cycles apart, count 1 during frame 1
    f0 = -1;
    f1 = -1;
    prev = tx;
    step(1'b0, 1'b1, BASE, 32'hA5);
    prev = tx;
    step(1'b0, 1'b1, BASE, 32'h3C);
    if (prev && !tx) f0 = cyc;
    prev = tx;
    for (int i = 0; i < 90; i++) begin
      if (i == 10) begin
        step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
        check("count_frame1", {28'd0, Read_data[7:4]}, 32'd1);
      end else begin
        step(1'b0, 1'b0, 32'd0, 32'd0);
      end
      if (prev && !tx && f0 >= 0 && f1 < 0 && cyc >= f0 + 40) f1 = cyc;
      prev = tx;
    end
    check("first_start_found", {31'd0, f0 >= 0}, 32'd1);
    check("start_spacing", 32'(f1 - f0), 32'd41);

    // Overflow: ten back-to-back writes; one leaves at the first pop, eight fill
    // the FIFO, the tenth is dropped
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, BASE, 32'(i));
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("ovf_set", {31'd0, Read_data[3]}, 32'd1);
    check("full_set", {31'd0, Read_data[1]}, 32'd1);
    step(1'b0, 1'b1, BASE + 32'd4, 32'h8);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("ovf_cleared", {31'd0, Read_data[3]}, 32'd0);
    idle_n(420);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("drained_status", Read_data, 32'h0000_0004);

    // Reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, BASE, 32'h11 * (i + 1));
    idle_n(12);
    reset = 1'b1;
    #1;
    check("tx_async_reset", {31'd0, tx}, 32'd1);
    m_reset();
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Address  = BASE + 32'd4;
    #1;
    check("status_in_reset", Read_data, 32'h0000_0004);
    @(negedge clk);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    reset = 1'b0;
    idle_n(100);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("status_after_reset", Read_data, 32'h0000_0004);

    // Random bus traffic against the model
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)
        step(1'b0, 1'b1, BASE, $urandom());
      else if (r < 14)
        step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
      else if (r < 16)
        step(1'b0, 1'b1, BASE + 32'd4, $urandom());
      else if (r < 20) begin
        a = BASE + 32'($urandom_range(0, 15));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom());
      end else if (r < 22) begin
        for (int j = 0; j < 6; j++) step(1'b0, 1'b1, BASE, $urandom());
      end else
        step(1'b0, 1'b0, 32'd0, 32'd0);
    end
    idle_n(450);
    step(1'b1, 1'b0, BASE + 32'd4, 32'd0);
    check("final_idle", {29'd0, Read_data[2:0]}, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
